// File: rtl/mem_access_stage.sv
// RV32I MEM stage: ALU results pass straight through; loads/stores run one req/gnt/rvalid
// bus transaction with byte-lane steering, load extension, upstream stall and a read timeout.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_flag_i,
  input  logic        wb_en_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        wb_en,
  output logic [4:0]  rd,
  output logic [31:0] result,
  output logic        s_flag_o,
  output logic        lsu_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_GNT = 2'd1, WAIT_RV = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic memop, illegal, accept, req, stall, err, done, active;

  // Select the addressed lane, then sign- or zero-extend by funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'b0, sh[7:0]};
      3'b101:  load_extract = {16'b0, sh[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  always_comb begin
    memop   = ~s_flag_i & (mem_rd_i | mem_wr_i);
    illegal = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11) | (mem_rd_i & mem_wr_i)
            | ((funct3_i[1:0] == 2'b01) & alu_result_i[0])
            | ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0]));

    dmem_we   = mem_wr_i;
    dmem_addr = {alu_result_i[31:2], 2'b00};
    case (funct3_i[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << alu_result_i[1:0];
        dmem_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        dmem_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data_i;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    req     = 1'b0;
    stall   = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (illegal) begin
            err = 1'b1;
          end else begin
            req    = 1'b1;
            accept = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        req    = 1'b1;
        accept = 1'b1;
      end
      WAIT_RV: begin
        if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant completes a store outright; a load moves on to wait for its data.
    if (accept) begin
      if (!dmem_gnt) begin
        stall   = 1'b1;
        state_d = WAIT_GNT;
      end else if (mem_wr_i) begin
        done    = 1'b1;
        state_d = IDLE;
      end else begin
        stall   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_RV;
      end
    end
  end

  always_comb begin
    active    = memop | (state_q != IDLE);
    dmem_req  = req & ~rst;
    stall_o   = stall & ~rst;
    lsu_err_o = err & ~rst;
    rd        = rd_i;
    if (active) begin
      s_flag_o = ~done;
      wb_en    = done & mem_rd_i & wb_en_i;
      result   = mem_rd_i ? load_extract(dmem_rdata, alu_result_i[1:0], funct3_i) : alu_result_i;
    end else begin
      s_flag_o = s_flag_i;
      wb_en    = wb_en_i & ~s_flag_i;
      result   = alu_result_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a vector table for single-cycle behaviour, hand sequences for
// multi-cycle corners, and randomized transactions checked against a cycle-level model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_flag_i, wb_en_i, mem_rd_i, mem_wr_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, store_data_i;
  logic [2:0]  funct3_i;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_o, wb_en, s_flag_o, lsu_err_o;
  logic [4:0]  rd;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_flag_i(s_flag_i), .wb_en_i(wb_en_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .funct3_i(funct3_i), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_o(stall_o), .wb_en(wb_en),
    .rd(rd), .result(result), .s_flag_o(s_flag_o), .lsu_err_o(lsu_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_alu(input logic [4:0] r, input logic [31:0] v);
    s_flag_i = 1'b0; wb_en_i = 1'b1; rd_i = r; alu_result_i = v; store_data_i = 32'h0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; funct3_i = 3'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // Cycle-level model of one instruction held in EX/MEM: g = cycles before grant,
  // v = cycles between grant and rvalid (v >= TIMEOUT means the data never arrives).
  task automatic run_txn(input logic mrd, input logic mwr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                         input int g, input int v, input logic wbi, input bit noise,
                         output int stalls, output int errs, output logic [31:0] res);
    int sz, off, last, bv;
    bit illegal, tmo, done, erx;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_res;
    logic [4:0]  erd;
    sz  = int'(f3[1:0]);
    off = int'(addr[1:0]);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (mrd && mwr)
           || (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
    exp_be = (sz == 0) ? 4'(1 << off) : (sz == 1) ? ((off >= 2) ? 4'd12 : 4'd3) : 4'd15;
    exp_wd = (sz == 0) ? 32'(sd[7:0]) * 32'h0101_0101 :
             (sz == 1) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    bv = int'(rdata >> (8 * off));
    if (sz == 0) begin
      bv = bv & 255;
      if (f3 == 3'd0 && bv > 127) bv = bv - 256;
    end else if (sz == 1) begin
      bv = bv & 65535;
      if (f3 == 3'd1 && bv > 32767) bv = bv - 65536;
    end
    exp_res = bv;
    tmo  = mrd && !mwr && v >= TIMEOUT;
    last = illegal ? 0 : mwr ? g : tmo ? g + TIMEOUT : g + 1 + v;
    s_flag_i = 1'b0; wb_en_i = wbi; rd_i = 5'($urandom); erd = rd_i;
    alu_result_i = addr; store_data_i = sd; mem_rd_i = mrd; mem_wr_i = mwr; funct3_i = f3;
    stalls = 0; errs = 0; res = 'x;
    for (int k = 0; k <= last; k++) begin
      dmem_gnt    = (k == g) || (noise && k > g && $urandom_range(1) == 1);
      dmem_rvalid = (mrd && !tmo && k == g + 1 + v) || (noise && k <= g && $urandom_range(1) == 1);
      dmem_rdata  = (k == g + 1 + v) ? rdata : $urandom;
      #4;
      done = (k == last) && !illegal && !tmo;
      erx  = (k == last) && (illegal || tmo);
      chk1("txn_req", dmem_req, !illegal && k <= g);
      chk1("txn_stall", stall_o, k != last);
      chk1("txn_err", lsu_err_o, erx);
      chk1("txn_s_flag", s_flag_o, !done);
      chk1("txn_wb_en", wb_en, done && mrd && wbi);
      chk("txn_rd", 32'(rd), 32'(erd));
      if (k == 0 && !illegal) begin
        chk("txn_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        chk("txn_be", 32'(dmem_be), 32'(exp_be));
        chk1("txn_we", dmem_we, mwr);
        if (mwr) chk("txn_wdata", dmem_wdata, exp_wd);
      end
      if (done && mrd) begin
        chk("txn_result", result, exp_res);
        res = result;
      end
      stalls += int'(stall_o);
      errs   += int'(lsu_err_o);
      @(posedge clk); #1;
    end
    set_alu(5'd0, 32'h0);
  endtask

  typedef struct {
    logic sf, wbi; logic [4:0] rdv; logic [31:0] alu, sd; logic mrd, mwr; logic [2:0] f3;
    logic gnt, ereq, estall, ewb, esf, eerr, cres; logic [31:0] eres;
    logic cbus; logic [3:0] ebe; logic [31:0] ewd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int stalls, errs;
    logic [31:0] res;

    vecs[0]  = '{'0,'1,5'd5,32'h1234,32'h0,'0,'0,3'd0,'0, '0,'0,'1,'0,'0, '1,32'h1234, '0,4'h0,32'h0};
    vecs[1]  = '{'0,'0,5'd7,32'hCAFE0001,32'h0,'0,'0,3'd3,'1, '0,'0,'0,'0,'0, '1,32'hCAFE0001, '0,4'h0,32'h0};
    vecs[2]  = '{'1,'1,5'd9,32'h40,32'h0,'1,'0,3'd2,'1, '0,'0,'0,'1,'0, '0,32'h0, '0,4'h0,32'h0};
    vecs[3]  = '{'0,'0,5'd1,32'h100,32'hDEADBEEF,'0,'1,3'd2,'1, '1,'0,'0,'0,'0, '0,32'h0, '1,4'hF,32'hDEADBEEF};
    vecs[4]  = '{'0,'0,5'd2,32'h102,32'h12345678,'0,'1,3'd0,'1, '1,'0,'0,'0,'0, '0,32'h0, '1,4'h4,32'h78787878};
    vecs[5]  = '{'0,'0,5'd3,32'h106,32'h12345678,'0,'1,3'd1,'1, '1,'0,'0,'0,'0, '0,32'h0, '1,4'hC,32'h56785678};
    vecs[6]  = '{'0,'1,5'd4,32'h102,32'h0,'1,'0,3'd2,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[7]  = '{'0,'1,5'd6,32'h101,32'h0,'1,'0,3'd1,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[8]  = '{'0,'1,5'd8,32'h100,32'h0,'1,'0,3'd3,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[9]  = '{'0,'1,5'd10,32'h100,32'h0,'1,'0,3'd6,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[10] = '{'0,'0,5'd11,32'h100,32'h0,'0,'1,3'd7,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[11] = '{'0,'1,5'd12,32'h100,32'h0,'1,'1,3'd2,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[12] = '{'0,'0,5'd13,32'h103,32'h0,'0,'1,3'd1,'1, '0,'0,'0,'1,'1, '0,32'h0, '0,4'h0,32'h0};
    vecs[13] = '{'0,'0,5'd14,32'h1,32'hA5,'0,'1,3'd0,'1, '1,'0,'0,'0,'0, '0,32'h0, '1,4'h2,32'hA5A5A5A5};

    // Reset with a legal load presented: control outputs must stay low.
    rst = 1'b1;
    set_alu(5'd0, 32'h0);
    mem_rd_i = 1'b1; funct3_i = 3'd2; alu_result_i = 32'h100; dmem_rdata = 32'h0;
    #3;
    chk1("reset_req", dmem_req, 1'b0);
    chk1("reset_stall", stall_o, 1'b0);
    chk1("reset_err", lsu_err_o, 1'b0);
    set_alu(5'd0, 32'h0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      s_flag_i = vecs[i].sf; wb_en_i = vecs[i].wbi; rd_i = vecs[i].rdv;
      alu_result_i = vecs[i].alu; store_data_i = vecs[i].sd; mem_rd_i = vecs[i].mrd;
      mem_wr_i = vecs[i].mwr; funct3_i = vecs[i].f3; dmem_gnt = vecs[i].gnt;
      dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      #4;
      chk1($sformatf("vec%0d_req", i), dmem_req, vecs[i].ereq);
      chk1($sformatf("vec%0d_stall", i), stall_o, vecs[i].estall);
      chk1($sformatf("vec%0d_wb_en", i), wb_en, vecs[i].ewb);
      chk1($sformatf("vec%0d_s_flag", i), s_flag_o, vecs[i].esf);
      chk1($sformatf("vec%0d_err", i), lsu_err_o, vecs[i].eerr);
      chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].rdv));
      if (vecs[i].cres) chk($sformatf("vec%0d_result", i), result, vecs[i].eres);
      if (vecs[i].cbus) begin
        chk($sformatf("vec%0d_addr", i), dmem_addr, vecs[i].alu & 32'hFFFF_FFFC);
        chk($sformatf("vec%0d_be", i), 32'(dmem_be), 32'(vecs[i].ebe));
        chk($sformatf("vec%0d_wdata", i), dmem_wdata, vecs[i].ewd);
        chk1($sformatf("vec%0d_we", i), dmem_we, vecs[i].mwr);
      end
      @(posedge clk); #1;
    end

    // LB @0x203, grant after two cycles, data one cycle later.
    run_txn(1'b1, 1'b0, 3'd0, 32'h203, 32'h0, 32'h80123456, 2, 0, 1'b1, 1'b0, stalls, errs, res);
    chk("lb_stall_cycles", 32'(stalls), 32'd3);
    chk("lb_result", res, 32'hFFFFFF80);

    // LHU @0x102 zero-extends the upper half.
    run_txn(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'hABCD0000, 0, 0, 1'b1, 1'b0, stalls, errs, res);
    chk("lhu_result", res, 32'h0000ABCD);

    // Granted load whose data never comes back.
    run_txn(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 100, 1'b1, 1'b0, stalls, errs, res);
    chk("timeout_stall_cycles", 32'(stalls), 32'(TIMEOUT));
    chk("timeout_err_pulses", 32'(errs), 32'd1);

    // Reset asserted while waiting for read data.
    set_alu(5'd0, 32'h0);
    mem_rd_i = 1'b1; funct3_i = 3'd2; alu_result_i = 32'h200; dmem_gnt = 1'b1;
    #4;
    chk1("rstmid_req_before", dmem_req, 1'b1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #1;
    chk1("rstmid_stall_before", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rstmid_req", dmem_req, 1'b0);
    chk1("rstmid_stall", stall_o, 1'b0);
    set_alu(5'd17, 32'h5A5A);
    #1;
    rst = 1'b0;
    #1;
    chk1("after_rst_wb_en", wb_en, 1'b1);
    chk("after_rst_result", result, 32'h5A5A);
    chk1("after_rst_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 32'h0BADF00D, 1, 1, 1'b1, 1'b0, stalls, errs, res);
    chk("after_rst_lw", res, 32'h0BADF00D);

    // Randomized transactions with spurious gnt/rvalid outside the expecting state.
    for (int t = 0; t < 40; t++) begin
      logic mrd, mwr;
      logic [2:0] f3;
      logic [31:0] addr;
      int g, v;
      mwr = 1'($urandom_range(1));
      mrd = !mwr;
      if ($urandom_range(15) == 0) begin mrd = 1'b1; mwr = 1'b1; end
      case ($urandom_range(4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2;
        3: f3 = mwr ? 3'd0 : 3'd4;
        default: f3 = mwr ? 3'd1 : 3'd5;
      endcase
      if ($urandom_range(9) == 0) f3 = 3'($urandom_range(7));
      addr = $urandom & 32'hFFFF_FFFC;
      if (f3[1:0] == 2'b00 || $urandom_range(4) == 0) addr[1:0] = 2'($urandom_range(3));
      else if (f3[1:0] == 2'b01) addr[1] = 1'($urandom_range(1));
      g = $urandom_range(3);
      v = ($urandom_range(7) == 0) ? 30 : $urandom_range(4);
      run_txn(mrd, mwr, f3, addr, $urandom, $urandom, g, v, 1'($urandom_range(1)), 1'b1,
              stalls, errs, res);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
